// File: rtl/branch_predictor_pkg.sv
// Shared decode constants, BHT counter encodings and init FSM states for branch_predictor.
// The optional return-address stack is enabled with the BPU_RAS_EN macro.
package branch_predictor_pkg;

    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_B_TYPE = 7'b1100011;

    // Register-field positions inside a 32-bit instruction word.
    localparam int RANGE_RD_HI  = 11;
    localparam int RANGE_RD_LO  = 7;
    localparam int RANGE_RS1_HI = 19;
    localparam int RANGE_RS1_LO = 15;

    localparam logic [4:0] REG_X0 = 5'd0;
    localparam logic [4:0] REG_X1 = 5'd1;
    localparam logic [4:0] REG_X5 = 5'd5;

    localparam logic [1:0] BHT_SNT = 2'b00;
    localparam logic [1:0] BHT_WNT = 2'b01;
    localparam logic [1:0] BHT_WT  = 2'b10;
    localparam logic [1:0] BHT_ST  = 2'b11;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bpu_state_e;

endpackage

// File: rtl/branch_predictor_bpu_ras.sv
// Circular return-address stack used by branch_predictor; only built when BPU_RAS_EN is defined.
// A push into a full stack overwrites the oldest entry.
`ifdef BPU_RAS_EN
module bpu_ras #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic [CNT_W-1:0] count;

    // ptr is the next free slot; the top of stack sits one below it.
    assign ptr_inc = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    assign ptr_dec = (ptr == '0) ? PTR_W'(DEPTH - 1) : ptr - PTR_W'(1);
    assign top     = mem[ptr_dec];
    assign empty   = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            mem[ptr] <= push_data;
            ptr      <= ptr_inc;
            if (count != CNT_W'(DEPTH)) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr   <= ptr_dec;
            count <= count - CNT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/branch_predictor.sv
// Fetch-stage next-PC generator: 2-bit saturating-counter BHT with an init sweep FSM.
// Define BPU_RAS_EN to add return-address-stack prediction of function returns.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int PC_SIZE    = 32,
    parameter int INSTR_SIZE = 32,
    parameter int BHT_IDX_W  = 6,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INSTR_SIZE-1:0] instr,
    input  logic [PC_SIZE-1:0]    pc,
    input  logic                  ld_stall,
    input  logic                  pc_sel,
    input  logic [PC_SIZE-1:0]    ex_pc,
    input  logic                  ex_br_valid,
    input  logic [PC_SIZE-1:0]    ex_br_pc,
    input  logic                  ex_br_taken,
    output logic [PC_SIZE-1:0]    pc_next,
    output logic                  pred_taken,
    output logic                  init_busy
);

    localparam int BHT_ENTRIES = 1 << BHT_IDX_W;

    logic [1:0]           bht [BHT_ENTRIES];
    bpu_state_e           state;
    bpu_state_e           state_next;
    logic [BHT_IDX_W-1:0] init_ptr;

    logic [6:0]           opcode;
    logic                 is_jal;
    logic                 is_br;
    logic [PC_SIZE-1:0]   j_imm;
    logic [PC_SIZE-1:0]   b_imm;
    logic [PC_SIZE-1:0]   pc_plus4;
    logic [BHT_IDX_W-1:0] lookup_idx;
    logic [BHT_IDX_W-1:0] update_idx;
    logic [1:0]           lookup_ctr;
    logic [1:0]           update_old;
    logic [1:0]           update_new;
    logic                 unused_pc_bits;

    assign opcode   = instr[6:0];
    assign is_jal   = (opcode == OPCODE_JAL);
    assign is_br    = (opcode == OPCODE_B_TYPE);
    assign j_imm    = {{(PC_SIZE-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign b_imm    = {{(PC_SIZE-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign pc_plus4 = pc + PC_SIZE'(4);

    assign lookup_idx     = pc[BHT_IDX_W+1:2];
    assign update_idx     = ex_br_pc[BHT_IDX_W+1:2];
    assign lookup_ctr     = bht[lookup_idx];
    assign update_old     = bht[update_idx];
    assign unused_pc_bits = ^{ex_br_pc[PC_SIZE-1:BHT_IDX_W+2], ex_br_pc[1:0]};

`ifdef BPU_RAS_EN
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic               is_link;
    logic               is_ret;
    logic               ras_push;
    logic               ras_pop;
    logic               ras_empty;
    logic [PC_SIZE-1:0] ras_top;

    assign rd      = instr[RANGE_RD_HI:RANGE_RD_LO];
    assign rs1     = instr[RANGE_RS1_HI:RANGE_RS1_LO];
    assign is_link = (rd == REG_X1) || (rd == REG_X5);
    assign is_ret  = (opcode == OPCODE_JALR) && ((rs1 == REG_X1) || (rs1 == REG_X5))
                     && (rd == REG_X0);

    bpu_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_SIZE)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                init_ptr <= init_ptr + BHT_IDX_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (init_ptr == '1) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    assign init_busy = (state == ST_INIT);

    always_comb begin
        update_new = update_old;
        if (ex_br_taken && update_old != BHT_ST) begin
            update_new = update_old + 2'd1;
        end else if (!ex_br_taken && update_old != BHT_SNT) begin
            update_new = update_old - 2'd1;
        end
    end

    // Counter storage carries no reset; the init sweep establishes its contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (init_busy) begin
                bht[init_ptr] <= BHT_WNT;
            end else if (ex_br_valid) begin
                bht[update_idx] <= update_new;
            end
        end
    end

    always_comb begin
        pc_next    = pc_plus4;
        pred_taken = 1'b0;
`ifdef BPU_RAS_EN
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
`endif
        if (pc_sel) begin
            pc_next = ex_pc;
        end else if (init_busy || ld_stall) begin
            pc_next = pc;
        end else if (is_jal) begin
            pc_next    = pc + j_imm;
            pred_taken = 1'b1;
`ifdef BPU_RAS_EN
            ras_push   = is_link;
`endif
        end
`ifdef BPU_RAS_EN
        else if (is_ret && !ras_empty) begin
            pc_next    = ras_top;
            pred_taken = 1'b1;
            ras_pop    = 1'b1;
        end
`endif
        else if (is_br && lookup_ctr[1]) begin
            pc_next    = pc + b_imm;
            pred_taken = 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed spot checks plus randomized traffic
// compared every cycle against a behavioural next-PC model (RAS part active with BPU_RAS_EN).
module tb_branch_predictor;

    typedef enum int {K_OTHER, K_BR, K_JAL, K_JALR} kind_e;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ld_stall;
    logic        pc_sel;
    logic [31:0] ex_pc;
    logic        ex_br_valid;
    logic [31:0] ex_br_pc;
    logic        ex_br_taken;
    logic [31:0] pc_next;
    logic        pred_taken;
    logic        init_busy;

    int total = 0;
    int bad   = 0;

    kind_e cur_kind;
    int    cur_imm;
    int    cur_rd;
    int    cur_rs1;

    // Behavioural model: counters as plain ints, init as a countdown, RAS as a queue.
    int          m_bht [64];
    int          m_init_left = 0;
    logic [31:0] m_ras [$];
    bit          m_live = 1'b0;

    branch_predictor dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .pc          (pc),
        .ld_stall    (ld_stall),
        .pc_sel      (pc_sel),
        .ex_pc       (ex_pc),
        .ex_br_valid (ex_br_valid),
        .ex_br_pc    (ex_br_pc),
        .ex_br_taken (ex_br_taken),
        .pc_next     (pc_next),
        .pred_taken  (pred_taken),
        .init_busy   (init_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic set_instr(input kind_e k, input int imm, input int rd, input int rs1);
        logic [31:0] iv;
        logic [4:0]  r_d;
        logic [4:0]  r_s;
        iv  = imm;
        r_d = 5'(rd);
        r_s = 5'(rs1);
        cur_kind = k;
        cur_imm  = imm;
        cur_rd   = rd;
        cur_rs1  = rs1;
        case (k)
            K_BR:    instr = {iv[12], iv[10:5], 5'd2, r_s, 3'b000, iv[4:1], iv[11], 7'b1100011};
            K_JAL:   instr = {iv[20], iv[10:1], iv[11], iv[19:12], r_d, 7'b1101111};
            K_JALR:  instr = {iv[11:0], r_s, 3'b000, r_d, 7'b1100111};
            default: instr = {$urandom_range(0, 32'h1FF_FFFF), 7'b0010011};
        endcase
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [32:0] m_pred();
        if (pc_sel) return {1'b0, ex_pc};
        if (m_init_left > 0 || ld_stall) return {1'b0, pc};
        if (cur_kind == K_JAL) return {1'b1, pc + 32'(cur_imm)};
`ifdef BPU_RAS_EN
        if (cur_kind == K_JALR && (cur_rs1 == 1 || cur_rs1 == 5) && cur_rd == 0 && m_ras.size() > 0)
            return {1'b1, m_ras[$]};
`endif
        if (cur_kind == K_BR && m_bht[pc[7:2]] >= 2) return {1'b1, pc + 32'(cur_imm)};
        return {1'b0, pc + 32'd4};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_init_left = 64;
            m_ras.delete();
            m_live = 1'b1;
        end else if (m_live) begin
            if (m_init_left > 0) begin
                m_init_left--;
                if (m_init_left == 0) begin
                    foreach (m_bht[i]) m_bht[i] = 1;
                end
            end else begin
`ifdef BPU_RAS_EN
                if (!pc_sel && !ld_stall) begin
                    if (cur_kind == K_JAL && (cur_rd == 1 || cur_rd == 5)) begin
                        m_ras.push_back(pc + 32'd4);
                        if (m_ras.size() > 4) void'(m_ras.pop_front());
                    end else if (cur_kind == K_JALR && (cur_rs1 == 1 || cur_rs1 == 5)
                                 && cur_rd == 0 && m_ras.size() > 0) begin
                        void'(m_ras.pop_back());
                    end
                end
`endif
                if (ex_br_valid) begin
                    if (ex_br_taken) m_bht[ex_br_pc[7:2]] = (m_bht[ex_br_pc[7:2]] < 3) ? m_bht[ex_br_pc[7:2]] + 1 : 3;
                    else             m_bht[ex_br_pc[7:2]] = (m_bht[ex_br_pc[7:2]] > 0) ? m_bht[ex_br_pc[7:2]] - 1 : 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (m_live) begin
            e = m_pred();
            check("model_pc_next", pc_next, e[31:0]);
            check("model_pred_taken", {31'd0, pred_taken}, {31'd0, e[32]});
            check("model_init_busy", {31'd0, init_busy}, {31'd0, (m_init_left > 0)});
        end
    end

    task automatic train(input logic [31:0] addr, input logic taken, input int n);
        set_instr(K_OTHER, 0, 0, 0);
        for (int i = 0; i < n; i++) begin
            cyc();
            ex_br_valid = 1'b1;
            ex_br_pc    = addr;
            ex_br_taken = taken;
        end
        cyc();
        ex_br_valid = 1'b0;
    endtask

    task automatic expect_now(input string name, input logic [31:0] exp_pc, input logic exp_pt);
        @(negedge clk);
        check({name, "_pc"}, pc_next, exp_pc);
        check({name, "_pt"}, {31'd0, pred_taken}, {31'd0, exp_pt});
    endtask

    initial begin
        rst = 1'b1; pc = 32'h0; ld_stall = 1'b0; pc_sel = 1'b0; ex_pc = 32'h0;
        ex_br_valid = 1'b0; ex_br_pc = 32'h0; ex_br_taken = 1'b0;
        set_instr(K_OTHER, 0, 0, 0);
        cyc();
        cyc();
        rst = 1'b0;

        // Init sweep: busy for exactly 64 cycles; taken updates arriving meanwhile are dropped.
        for (int i = 0; i < 64; i++) begin
            pc          = 32'h40 + 32'(i * 4);
            ex_br_valid = 1'b1;
            ex_br_pc    = 32'h100;
            ex_br_taken = 1'b1;
            set_instr(K_JAL, 64, 0, 0);
            @(negedge clk);
            check("init_busy_high", {31'd0, init_busy}, 32'd1);
            check("init_hold_pc", pc_next, pc);
            cyc();
        end
        ex_br_valid = 1'b0;
        set_instr(K_OTHER, 0, 0, 0);
        @(negedge clk);
        check("init_busy_low", {31'd0, init_busy}, 32'd0);

        cyc();
        pc = 32'h100;
        set_instr(K_BR, -16, 0, 1);
        expect_now("beq_fresh", 32'h104, 1'b0);
        train(32'h100, 1'b1, 2);
        pc = 32'h100;
        set_instr(K_BR, -16, 0, 1);
        expect_now("beq_trained", 32'h0F0, 1'b1);

        train(32'h180, 1'b1, 5);
        train(32'h180, 1'b0, 1);
        pc = 32'h180;
        set_instr(K_BR, 32, 0, 1);
        expect_now("sat_one_nt", 32'h1A0, 1'b1);
        train(32'h180, 1'b0, 2);
        pc = 32'h180;
        set_instr(K_BR, 32, 0, 1);
        expect_now("sat_three_nt", 32'h184, 1'b0);

        cyc();
        pc = 32'h200;
        set_instr(K_JAL, 32'h40, 0, 0);
        ld_stall = 1'b1;
        expect_now("jal_stall", 32'h200, 1'b0);
        cyc();
        pc_sel = 1'b1;
        ex_pc  = 32'h400;
        expect_now("pc_sel_wins", 32'h400, 1'b0);
        cyc();
        pc_sel = 1'b0;
        ld_stall = 1'b0;
        expect_now("jal_plain", 32'h240, 1'b1);

        cyc();
        pc = 32'hFFFF_FFFC;
        set_instr(K_OTHER, 0, 0, 0);
        expect_now("wrap", 32'h0000_0000, 1'b0);

`ifdef BPU_RAS_EN
        cyc();
        pc = 32'h300;
        set_instr(K_JAL, 32'h200, 1, 0);
        expect_now("call", 32'h500, 1'b1);
        cyc();
        pc = 32'h500;
        set_instr(K_JALR, 0, 0, 1);
        expect_now("ret_hit", 32'h304, 1'b1);
        cyc();
        expect_now("ret_empty", 32'h504, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            pc = 32'h1000 + 32'(i * 4);
            set_instr(K_JAL, 8, 1, 0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            pc = 32'h2000;
            set_instr(K_JALR, 0, 0, 1);
            expect_now("ras_newest", 32'h1014 - 32'(i * 4), 1'b1);
        end
        cyc();
        expect_now("ras_drained", 32'h2004, 1'b0);
`else
        cyc();
        pc = 32'h500;
        set_instr(K_JALR, 0, 0, 1);
        expect_now("ret_no_ras", 32'h504, 1'b0);
`endif

        // Randomized traffic, checked every cycle by the model compare process.
        for (int n = 0; n < 3000; n++) begin
            int k;
            int pick;
            cyc();
            rst         = ($urandom_range(0, 399) == 0);
            pc_sel      = ($urandom_range(0, 9) == 0);
            ex_pc       = $urandom & 32'hFFFF_FFFC;
            ld_stall    = ($urandom_range(0, 7) == 0);
            ex_br_valid = $urandom_range(0, 1) == 1;
            ex_br_pc    = 32'h100 + 32'($urandom_range(0, 7) * 4);
            ex_br_taken = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 9) == 0) pc = $urandom & 32'hFFFF_FFFC;
            else                           pc = 32'h100 + 32'($urandom_range(0, 7) * 4);
            k = $urandom_range(0, 3);
            case (k)
                0: set_instr(K_BR, (int'($urandom_range(0, 4095)) - 2048) * 2, 0, 1);
                1: begin
                    pick = $urandom_range(0, 3);
                    set_instr(K_JAL, (int'($urandom_range(0, 1048575)) - 524288) * 2,
                              (pick == 0) ? 0 : (pick == 1) ? 1 : (pick == 2) ? 5 : 3, 0);
                end
                2: begin
                    pick = $urandom_range(0, 2);
                    set_instr(K_JALR, 0, ($urandom_range(0, 2) == 0) ? 1 : 0,
                              (pick == 0) ? 1 : (pick == 1) ? 5 : 2);
                end
                default: set_instr(K_OTHER, 0, 0, 0);
            endcase
        end
        cyc();
        rst = 1'b0;
        pc_sel = 1'b0;
        ld_stall = 1'b0;
        ex_br_valid = 1'b0;
        for (int n = 0; n < 70; n++) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
